shift_arbiter: RTL and testbench
================================

# shift_arbiter

Sequential controller sharing one `Shifter` datapath instance between two requesters: port 0 for ALU shift ops and port 1 for load/store byte-lane alignment. It accepts at most one request at a time using a valid/ready handshake and arbitrates by round-robin. It registers operands and the result, then holds the response until the owning requester takes it. It sits between the execute stage and the shared shifter in the MS2 datapath.

## Interface
Parameters:
- `RR_INIT`, default 0: requester given priority after reset.
- `FIXED_PRIO`, default 0: when 1, port 0 always wins and the round-robin pointer is ignored.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a` / `req1_a`  in  32  operand.
- `req0_shamt` / `req1_shamt`  in  5  shift amount.
- `req0_type` / `req1_type`  in  2  shift type.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that port.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp_result`  out  32  result, shared by both response ports.
- `busy`  out  1  state is not IDLE.

## Operation
- Shift type encoding (2-bit): SRL=2'b00, SLL=2'b01, SRA=2'b10, 2'b11=reserved.
- A reserved type produces result 0 and is otherwise handled as a normal request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the valid requester if only one is valid.
  - If both are valid, grant goes to the priority-pointer port.
  - `reqN_ready` is asserted combinationally, in the same cycle, for the granted port only.
  - On grant: capture a/shamt/type and the owner ID; flip the pointer to the other port (round-robin mode only); go to EXEC.
- EXEC:
  - The captured operands drive `Shifter`; its output is registered into `rsp_result`.
  - Go to RESP.
- RESP:
  - `rspN_valid` is high for the owner only; `rsp_result` is stable.
  - When `rspN_ready` of the owner is high, return to IDLE.
  - `rspN_ready` of the non-owner is ignored.
- Requests are never accepted outside IDLE: both `reqN_ready` are 0 in EXEC and RESP.
- The pointer changes only on a grant, so a lone requester does not starve the pointer.
- SRA sign-extends from bit 31. shamt 0 returns a unchanged for all three valid types.

## Timing
- Reset (`rst` high at a clock edge):
  - state=IDLE, pointer=`RR_INIT`.
  - `rsp_result`=0, `rspN_valid`=0, `busy`=0.
  - `reqN_ready`=0 during the reset cycle.
- Latency: request accepted in cycle N → `rspN_valid` high from cycle N+2.
- Minimum initiation interval: 3 cycles (accept N, response taken N+2, next accept N+3).
- `rspN_valid` stays high with `rsp_result` unchanged until the owner's ready is sampled high.
- Requester input changes after acceptance have no effect, because operands are captured.
- Reset asserted in EXEC or RESP: the in-flight request is dropped with no response; the next cycle is IDLE.
- Both requesters valid every cycle: grants alternate 0,1,0,1 (round-robin mode).

## Structure
- Shared package (`defines.v`) holds:
  - the shift-type codes SHIFT_SRL, SHIFT_SLL, SHIFT_SRA;
  - the state encodings ST_IDLE, ST_EXEC, ST_RESP.
- Sub-module: one instance of `Shifter`, fed only from the captured operand registers.
- Arbitration logic and FSM live in this module; no further hierarchy.

## Test plan
- Reset, then single SLL on port 0:
  - stimulus: a=0x0000_0001, shamt=4.
  - required: `rsp0_valid` at N+2 with `rsp_result`=0x0000_0010; `rsp1_valid` stays 0.
- SRA and SRL on port 1, shamt=8:
  - a=0x8000_0000 with SRA → 0xFF80_0000.
  - same a with SRL → 0x0080_0000.
- Contention, both valid continuously from reset with `RR_INIT`=0:
  - required grant order 0,1,0,1.
  - with `FIXED_PRIO`=1: all four grants go to port 0.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles.
  - required: `rsp0_valid` and `rsp_result` stable throughout.
  - both `reqN_ready` stay 0; accept occurs the cycle after the response is taken.
- Edge cases:
  - reserved type 2'b11 → result 0;
  - shamt=0 with SRA, a=0xDEAD_BEEF → 0xDEAD_BEEF;
  - shamt=31 with SRA, a=0x8000_0000 → 0xFFFF_FFFF.
- Mid-operation reset:
  - stimulus: assert `rst` in EXEC.
  - required: no `rspN_valid` follows; the next request completes normally with the correct result.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter.
// Holds the shift-type codes, the controller state encoding and the
// captured-operand record that feeds the shared shifter.
package shift_arbiter_pkg;

    localparam logic [1:0] SHIFT_SRL = 2'b00;
    localparam logic [1:0] SHIFT_SLL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    // 2'b11 is reserved and yields a zero result

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  typ;
    } shift_op_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Shared 32-bit shifter datapath.
// Ports:
//   op     - captured operand record (a, shamt, typ)
//   result - shifted value; SRA sign-extends from bit 31, reserved type gives 0
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
(
    input  shift_op_t   op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op.typ)
            SHIFT_SRL: result = op.a >> op.shamt;
            SHIFT_SLL: result = op.a << op.shamt;
            SHIFT_SRA: result = $unsigned($signed(op.a) >>> op.shamt);
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter sharing one shifter between the ALU shift
// port (0) and the load/store alignment port (1). One request in flight at
// a time: accept in IDLE, compute in EXEC, hold the response in RESP until
// the owning port takes it.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   reqN_valid/ready              - request handshake (ready is combinational)
//   reqN_a/shamt/type             - request operands
//   rspN_valid/ready              - response handshake, valid only for owner
//   rsp_result                    - registered result shared by both ports
//   busy                          - controller not in IDLE
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RR_INIT    = 1'b0,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_type,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_type,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    state_t      state;
    logic        ptr;
    logic        owner;
    shift_op_t   op_q;
    logic [31:0] shift_out;
    logic        grant_id;
    logic        accept;
    logic        taken;

    // Contention goes to the pointer port; a lone requester always wins.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid)
            grant_id = FIXED_PRIO ? 1'b0 : ptr;
    end

    // Gated by rst so nothing is acknowledged during the reset cycle.
    assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid) && !rst;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    // Only the owner's ready can retire the response.
    assign taken = owner ? rsp1_ready : rsp0_ready;

    shift_arbiter_shifter u_shifter (
        .op     (op_q),
        .result (shift_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= RR_INIT;
            owner      <= 1'b0;
            op_q       <= '0;
            rsp_result <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= grant_id ? {req1_a, req1_shamt, req1_type}
                                          : {req0_a, req0_shamt, req0_type};
                        owner <= grant_id;
                        // Priority passes to the port that was not served.
                        if (!FIXED_PRIO)
                            ptr <= ~grant_id;
                        state <= ST_EXEC;
                        busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= shift_out;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (taken) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, contention
// sequences for round-robin and fixed priority, mid-operation reset, and
// randomized transactions checked against an arithmetic reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req1_a = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic [1:0]  req0_type = '0, req1_type = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        busy;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy;
    logic [31:0] f_rsp_result;

    int total = 0;
    int bad   = 0;
    int ptr   = 0;   // model of the round-robin priority port

    always #5 clk = ~clk;

    shift_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_shamt(req0_shamt), .req0_type(req0_type),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_shamt(req1_shamt), .req1_type(req1_type),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .busy(busy)
    );

    shift_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready),
        .req0_a(req0_a), .req0_shamt(req0_shamt), .req0_type(req0_type),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready),
        .req1_a(req1_a), .req1_shamt(req1_shamt), .req1_type(req1_type),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(f_rsp_result), .busy(f_busy)
    );

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0;
        logic [4:0]  s0;
        logic [1:0]  t0;
        logic [31:0] a1;
        logic [4:0]  s1;
        logic [1:0]  t1;
        int          stall;
        int          eg;
        logic [31:0] er;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shifts as multiplication / floor division by 2**sh.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh,
                                              input logic [1:0] t);
        longint v, p, sv, q, r;
        p = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        v = 0;
        v[31:0] = a;
        case (t)
            2'd0: q = v / p;
            2'd1: begin r = (v * p) % 64'h1_0000_0000; q = r; end
            2'd2: begin
                sv = a[31] ? v - 64'h1_0000_0000 : v;
                if (sv >= 0) q = sv / p;
                else         q = -((-sv + p - 1) / p);
            end
            default: q = 0;
        endcase
        return q[31:0];
    endfunction

    // Starts and ends just after a rising edge with the DUT in IDLE.
    task automatic run_txn(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_shamt = v.s0; req0_type = v.t0;
        req1_valid = v.v1; req1_a = v.a1; req1_shamt = v.s1; req1_type = v.t1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("grant0", req0_ready, v.eg == 0);
        chk("grant1", req1_ready, v.eg == 1);
        @(posedge clk); #1;
        // operands change and requests stay up: must neither matter nor be accepted
        req0_a = $urandom; req0_shamt = 5'($urandom); req0_type = 2'($urandom);
        req1_a = $urandom; req1_shamt = 5'($urandom); req1_type = 2'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("exec_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        for (int i = 0; i < v.stall; i++) begin
            if (v.eg == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            @(negedge clk);
            chk("hold_owner_valid", v.eg ? rsp1_valid : rsp0_valid, 1);
            chk("hold_other_valid", v.eg ? rsp0_valid : rsp1_valid, 0);
            chk("hold_result", rsp_result, v.er);
            chk("hold_ready", {req0_ready, req1_ready}, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = (v.eg == 0); rsp1_ready = (v.eg == 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("rsp_owner_valid", v.eg ? rsp1_valid : rsp0_valid, 1);
        chk("rsp_other_valid", v.eg ? rsp0_valid : rsp1_valid, 0);
        chk("rsp_result", rsp_result, v.er);
        chk("rsp_busy", busy, 1);
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 0;
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   gq[$];
    int   fq[$];

    initial begin
        //          v0 v1 a0            s0 t0     a1            s1 t1     st eg er
        vecs[0] = '{1, 0, 32'h0000_0001, 4, 2'b01, 32'h0,        0, 2'b00, 0, 0, 32'h0000_0010};
        vecs[1] = '{0, 1, 32'h0,         0, 2'b00, 32'h8000_0000, 8, 2'b10, 0, 1, 32'hFF80_0000};
        vecs[2] = '{1, 1, 32'hFFFF_FFFF, 3, 2'b11, 32'h1234_5678, 1, 2'b01, 5, 0, 32'h0000_0000};
        vecs[3] = '{0, 1, 32'h0,         0, 2'b00, 32'h8000_0000, 8, 2'b00, 0, 1, 32'h0080_0000};
        vecs[4] = '{1, 1, 32'h8000_0000, 31, 2'b10, 32'h5555_5555, 2, 2'b00, 1, 0, 32'hFFFF_FFFF};
        vecs[5] = '{1, 1, 32'h0000_00FF, 4, 2'b01, 32'hDEAD_BEEF, 0, 2'b10, 2, 1, 32'hDEAD_BEEF};
        vecs[6] = '{1, 0, 32'h0000_0003, 31, 2'b01, 32'h0,       0, 2'b00, 0, 0, 32'h8000_0000};
        vecs[7] = '{0, 1, 32'h0,         0, 2'b00, 32'h1234_5678, 0, 2'b00, 3, 1, 32'h1234_5678};

        // reset: nothing acknowledged while rst is high
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("reset_result", rsp_result, 0);
        @(posedge clk); #1;
        ptr = 0;

        // directed table; back-to-back calls check accept right after take
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
            ptr = 1 - vecs[i].eg;
        end

        // contention from reset: both ports always valid, responses taken at once
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (f_req0_ready) fq.push_back(0);
            if (f_req1_ready) fq.push_back(1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk("rr_grant_count", gq.size(), 4);
        chk("fixed_grant_count", fq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant_order", (i < gq.size()) ? gq[i] : 9, i % 2);
            chk("fixed_grant_order", (i < fq.size()) ? fq[i] : 9, 0);
        end
        do_reset();

        // reset while in EXEC drops the request
        req0_valid = 1'b1; req0_a = 32'h0000_000F; req0_shamt = 5'd8; req0_type = 2'b01;
        @(negedge clk);
        chk("midrst_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_exec_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_result", rsp_result, 0);
            @(posedge clk); #1;
        end
        rv = '{1, 0, 32'h0000_000F, 8, 2'b01, 32'h0, 0, 2'b00, 0, 0, 32'h0000_0F00};
        run_txn(rv);
        ptr = 1;

        // randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            rv.v0 = pat[0]; rv.v1 = pat[1];
            rv.a0 = $urandom; rv.s0 = 5'($urandom); rv.t0 = 2'($urandom);
            rv.a1 = $urandom; rv.s1 = 5'($urandom); rv.t1 = 2'($urandom);
            rv.stall = int'($urandom_range(0, 3));
            rv.eg = (rv.v0 && rv.v1) ? ptr : (rv.v1 ? 1 : 0);
            rv.er = (rv.eg == 0) ? ref_shift(rv.a0, int'(rv.s0), rv.t0)
                                 : ref_shift(rv.a1, int'(rv.s1), rv.t1);
            run_txn(rv);
            ptr = 1 - rv.eg;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
